pipeline_stall_ctrl: RTL and testbench

//   Hazard/stall sequencer for the 5-stage pipeline. Decides each cycle whether the instruction in D may advance into the
//   E-stage pipeline register. Drives the write enables of the PC and D register, and the bubble-insert clear of the E register.

---
 rtl/pipeline_stall_ctrl_pkg.sv | 32 +++
 rtl/pipeline_stall_ctrl_md_busy_timer.sv | 49 ++++
 rtl/pipeline_stall_ctrl.sv | 100 ++++++++++
 tb/tb_pipeline_stall_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/pipeline_stall_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl_pkg
//  Purpose  : Shared pipeline timing constants: Tuse/Tnew encodings for each
//             instruction class and default multiply/divide latencies. The
//             same constants feed the decoder, the forwarding mux selects and
//             the hazard/stall sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
package pipeline_stall_ctrl_pkg;

  typedef logic [4:0] reg_idx_t;  // architectural register number
  typedef logic [1:0] timing_t;   // Tuse / Tnew cycle count

  // Tuse: cycles from D until the operand is consumed.
  localparam timing_t TUSE_BRANCH = 2'd0;  // compared in D
  localparam timing_t TUSE_ALU    = 2'd1;  // consumed by the ALU in E
  localparam timing_t TUSE_STORE  = 2'd2;  // store data consumed in M
  localparam timing_t TUSE_NONE   = 2'd3;  // operand not read

  // Tnew: cycles until a stage's result can be forwarded.
  localparam timing_t TNEW_READY  = 2'd0;  // result already available
  localparam timing_t TNEW_ALU_E  = 2'd1;  // ALU result while still in E
  localparam timing_t TNEW_LOAD_E = 2'd2;  // load result while still in E

  // Default multi-cycle unit occupancy.
  localparam int MULT_LAT_DEF = 5;
  localparam int DIV_LAT_DEF  = 10;
  localparam int CNT_W_DEF    = 4;

endpackage : pipeline_stall_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_stall_ctrl_md_busy_timer.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl_md_busy_timer
//  Purpose  : Busy countdown of the multiply/divide unit. A start while idle
//             loads the operation latency; the count then decrements to zero.
//             A start while busy is ignored.
//  Ports    : clk    - clock, rising edge
//             reset  - asynchronous, active-high; clears the count at once
//             start  - mult/div issued this cycle
//             is_div - qualifies start: 1 = divide, 0 = multiply
//             busy   - count nonzero
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl_md_busy_timer
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic start,
  input  logic is_div,
  output logic busy
);

  localparam logic [CNT_W-1:0] C_MULT_LOAD = CNT_W'(MULT_LAT);
  localparam logic [CNT_W-1:0] C_DIV_LOAD  = CNT_W'(DIV_LAT);

  logic [CNT_W-1:0] r_count;
  logic             w_busy;

  assign w_busy = (r_count != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (start && !w_busy) begin
      r_count <= is_div ? C_DIV_LOAD : C_MULT_LOAD;
    end else if (w_busy) begin
      r_count <= r_count - {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign busy = w_busy;

endmodule : pipeline_stall_ctrl_md_busy_timer
`default_nettype wire

// File: rtl/pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipeline_stall_ctrl
//  Purpose  : Hazard/stall sequencer for the 5-stage pipeline. Decides each
//             cycle whether the D-stage instruction may advance into E, drives
//             the PC / D-register write enables and the E-register bubble
//             clear, tracks MDU occupancy and counts stalled cycles.
//  Ports    : clk, reset            - clock / async active-high reset
//             d_rs, d_rt            - D-stage source registers
//             d_tuse_rs, d_tuse_rt  - Tuse per source (3 = not used)
//             d_is_md               - D instruction touches the MDU
//             e_wa, e_tnew          - E-stage destination and Tnew
//             m_wa, m_tnew          - M-stage destination and Tnew
//             md_start, md_is_div   - E-stage MDU issue and its kind
//             stall                 - hazard present this cycle
//             pc_we, dreg_we        - write enables (= ~stall)
//             ereg_clr              - insert bubble into E (= stall)
//             md_busy               - MDU countdown nonzero
//             stall_cnt             - saturating count of stalled cycles
//  Revision : 1.0 - initial release
// ============================================================================
module pipeline_stall_ctrl
  import pipeline_stall_ctrl_pkg::*;
#(
  parameter int MULT_LAT = MULT_LAT_DEF,
  parameter int DIV_LAT  = DIV_LAT_DEF,
  parameter int CNT_W    = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  d_rs,
  input  logic [4:0]  d_rt,
  input  logic [1:0]  d_tuse_rs,
  input  logic [1:0]  d_tuse_rt,
  input  logic        d_is_md,
  input  logic [4:0]  e_wa,
  input  logic [1:0]  e_tnew,
  input  logic [4:0]  m_wa,
  input  logic [1:0]  m_tnew,
  input  logic        md_start,
  input  logic        md_is_div,
  output logic        stall,
  output logic        pc_we,
  output logic        dreg_we,
  output logic        ereg_clr,
  output logic        md_busy,
  output logic [31:0] stall_cnt
);

  logic        w_md_busy;
  logic        w_rs_hazard;
  logic        w_rt_hazard;
  logic        w_md_hazard;
  logic        w_stall;
  logic [31:0] r_stall_cnt;

  // A producer only forces a stall when its result arrives strictly later
  // than the consumer needs it; equal timing is covered by forwarding.
  // Register 0 is hard-wired and never creates a dependency. A Tuse of 3
  // can never be below a 2-bit Tnew, so unused operands never stall.
  assign w_rs_hazard = ((d_rs != 5'd0) && (d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                       ((d_rs != 5'd0) && (d_rs == m_wa) && (d_tuse_rs < m_tnew));
  assign w_rt_hazard = ((d_rt != 5'd0) && (d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                       ((d_rt != 5'd0) && (d_rt == m_wa) && (d_tuse_rt < m_tnew));

  // md_start is included so an MDU access directly behind the issuing
  // mult/div is held before the busy flag has had a chance to rise.
  assign w_md_hazard = d_is_md && (w_md_busy || md_start);

  assign w_stall = w_rs_hazard || w_rt_hazard || w_md_hazard;

  pipeline_stall_ctrl_md_busy_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_busy_timer (
    .clk    (clk),
    .reset  (reset),
    .start  (md_start),
    .is_div (md_is_div),
    .busy   (w_md_busy)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stall_cnt <= 32'd0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign stall     = w_stall;
  assign pc_we     = ~w_stall;
  assign dreg_we   = ~w_stall;
  assign ereg_clr  = w_stall;
  assign md_busy   = w_md_busy;
  assign stall_cnt = r_stall_cnt;

endmodule : pipeline_stall_ctrl
`default_nettype wire

// File: tb/tb_pipeline_stall_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipeline_stall_ctrl
//  Purpose  : Directed scoreboard bench for pipeline_stall_ctrl. The driver
//             pushes the hand-computed response for each cycle; a monitor on
//             the falling edge pops and compares.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_stall_ctrl;

  logic        clk;
  logic        reset;
  logic [4:0]  d_rs, d_rt, e_wa, m_wa;
  logic [1:0]  d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic        d_is_md, md_start, md_is_div;
  logic        stall, pc_we, dreg_we, ereg_clr, md_busy;
  logic [31:0] stall_cnt;

  typedef struct packed {
    logic        stall;
    logic        busy;
    logic [31:0] cnt;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];

  int          checks;
  int          fails;
  logic [31:0] exp_cnt;

  pipeline_stall_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .d_rs      (d_rs),
    .d_rt      (d_rt),
    .d_tuse_rs (d_tuse_rs),
    .d_tuse_rt (d_tuse_rt),
    .d_is_md   (d_is_md),
    .e_wa      (e_wa),
    .e_tnew    (e_tnew),
    .m_wa      (m_wa),
    .m_tnew    (m_tnew),
    .md_start  (md_start),
    .md_is_div (md_is_div),
    .stall     (stall),
    .pc_we     (pc_we),
    .dreg_we   (dreg_we),
    .ereg_clr  (ereg_clr),
    .md_busy   (md_busy),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, req, $time);
    end
  endtask

  // Monitor: the DUT presents a response every cycle; compare on the
  // falling edge, away from the active edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e;
      string n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      chk({n, ".stall"},     {31'd0, stall},    {31'd0, e.stall});
      chk({n, ".pc_we"},     {31'd0, pc_we},    {31'd0, ~e.stall});
      chk({n, ".dreg_we"},   {31'd0, dreg_we},  {31'd0, ~e.stall});
      chk({n, ".ereg_clr"},  {31'd0, ereg_clr}, {31'd0, e.stall});
      chk({n, ".md_busy"},   {31'd0, md_busy},  {31'd0, e.busy});
      chk({n, ".stall_cnt"}, stall_cnt,         e.cnt);
    end
  end

  // Push the expected response for the current inputs, advance one clock,
  // and account for the stall counter update at that edge.
  task automatic step(input string nm, input logic s, input logic b);
    exp_t e;
    e.stall = s;
    e.busy  = b;
    e.cnt   = exp_cnt;
    exp_q.push_back(e);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
    if (reset)
      exp_cnt = 32'd0;
    else if (s && exp_cnt != 32'hFFFF_FFFF)
      exp_cnt = exp_cnt + 32'd1;
  endtask

  task automatic clear_inputs();
    d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3;
    d_is_md = 1'b0; e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    md_start = 1'b0; md_is_div = 1'b0;
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    exp_cnt = 32'd0;
    clear_inputs();
    d_tuse_rs = 2'd0;
    d_tuse_rt = 2'd0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // 1: reset state, all inputs zero
    step("reset", 1'b0, 1'b0);

    // 2: load-use on rs: E then M producer, then ready
    clear_inputs();
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd2;
    step("loaduse_e", 1'b1, 1'b0);
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd5; m_tnew = 2'd1;
    step("loaduse_m", 1'b1, 1'b0);
    m_tnew = 2'd0;
    step("loaduse_rel", 1'b0, 1'b0);  // stall_cnt must read 2 here

    // 3: forwardable and non-dependent cases
    clear_inputs();
    d_rt = 5'd8; d_tuse_rt = 2'd1; e_wa = 5'd8; e_tnew = 2'd1;
    step("fwd_equal", 1'b0, 1'b0);
    d_rt = 5'd0; e_wa = 5'd0; e_tnew = 2'd2;
    step("fwd_r0", 1'b0, 1'b0);
    clear_inputs();
    d_rs = 5'd7; d_tuse_rs = 2'd3; e_wa = 5'd7; e_tnew = 2'd3;
    step("tuse_none", 1'b0, 1'b0);
    clear_inputs();
    d_rt = 5'd9; d_tuse_rt = 2'd0; m_wa = 5'd9; m_tnew = 2'd1;
    step("rt_m_haz", 1'b1, 1'b0);
    d_rt = 5'd10;
    step("rt_m_nodep", 1'b0, 1'b0);

    // 4a: multiply, 5 busy cycles; a second start mid-run is ignored
    clear_inputs();
    md_start = 1'b1; md_is_div = 1'b0; d_is_md = 1'b1;
    step("mult_start", 1'b1, 1'b0);
    md_start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      md_start  = (i == 1);
      md_is_div = (i == 1);
      step("mult_busy", 1'b1, 1'b1);
    end
    md_start = 1'b0; md_is_div = 1'b0;
    step("mult_done", 1'b0, 1'b0);

    // 4b: divide, 10 busy cycles
    md_start = 1'b1; md_is_div = 1'b1;
    step("div_start", 1'b1, 1'b0);
    md_start = 1'b0;
    for (int i = 0; i < 10; i++) step("div_busy", 1'b1, 1'b1);
    step("div_done", 1'b0, 1'b0);

    // 5: reset in mid-countdown (count 6) takes effect without a clock
    md_start = 1'b1; md_is_div = 1'b1;
    step("div2_start", 1'b1, 1'b0);
    md_start = 1'b0;
    for (int i = 0; i < 4; i++) step("div2_busy", 1'b1, 1'b1);
    reset   = 1'b1;
    exp_cnt = 32'd0;
    step("async_reset", 1'b0, 1'b0);
    reset = 1'b0;
    step("after_reset", 1'b0, 1'b0);

    // 6: saturation of the stall counter, preset near the top
    clear_inputs();
    dut.r_stall_cnt = 32'hFFFF_FFFD;
    exp_cnt = 32'hFFFF_FFFD;
    d_rs = 5'd5; d_tuse_rs = 2'd0; e_wa = 5'd5; e_tnew = 2'd2;
    for (int i = 0; i < 5; i++) step("saturate", 1'b1, 1'b0);
    clear_inputs();
    step("sat_hold", 1'b0, 1'b0);

    // drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_pipeline_stall_ctrl
`default_nettype wire
